// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ valid/ready producers.
// A grant lasts for up to MAX_BURST words, and there is always one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BCW       = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [BCW-1:0]   cnt_q, cnt_d;

  logic [IDW-1:0]   pick;
  logic             anyValid;
  logic [IDW-1:0]   ownerNext;
  logic             ownerValid;
  logic [DSIZE-1:0] ownerData;
  logic             active;
  logic             xfer;
  logic             lastWord;
  logic             endBurst;

  // Rotating-priority search: the first valid requester at or after ptr wins.
  always_comb begin
    int unsigned idx;
    pick     = '0;
    anyValid = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!anyValid && req_valid[idx]) begin
        anyValid = 1'b1;
        pick     = IDW'(idx);
      end
    end
  end

  // Owner mux written as a loop, so no index outside 0..NREQ-1 is ever formed.
  always_comb begin
    ownerValid = 1'b0;
    ownerData  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        ownerValid = req_valid[i];
        ownerData  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign ownerNext = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
  assign active    = (state_q == BURST) && !rst;
  assign xfer      = active && ownerValid && !fifo_wfull;
  assign lastWord  = (cnt_q == BCW'(MAX_BURST - 1));
  assign endBurst  = xfer ? lastWord : !ownerValid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (anyValid) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // A full FIFO with the owner still valid stalls here with no timeout.
        if (endBurst) begin
          ptr_d   = ownerNext;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while rst is high, even if the state is still BURST.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = active && (owner_q == IDW'(i)) && !fifo_wfull;
    end
  end

  assign grant_valid = active;
  assign grant_id    = rst ? '0 : owner_q;
  assign fifo_wdata  = active ? ownerData : '0;
  assign fifo_winc   = xfer;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer models feed per-requester scoreboards,
// and a negedge monitor matches every FIFO write against them.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic [7:0]  fifoWdata;
  logic        fifoWinc;
  logic        fifoWfull;
  logic        grantValid;
  logic [1:0]  grantId;

  logic [3:0]  reqValid1;
  logic [31:0] reqData1;
  logic [3:0]  reqReady1;
  logic [7:0]  fifoWdata1;
  logic        fifoWinc1;
  logic        fifoWfull1;
  logic        grantValid1;
  logic [1:0]  grantId1;

  logic [7:0]  words [4][8];
  int          n [4];
  int          pos [4];
  logic [7:0]  expQ [4][$];
  logic [3:0]  acc;

  int          checkCount;
  int          passCount;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_data(reqData), .req_ready(reqReady),
    .fifo_wdata(fifoWdata), .fifo_winc(fifoWinc), .fifo_wfull(fifoWfull),
    .grant_valid(grantValid), .grant_id(grantId)
  );

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid1), .req_data(reqData1), .req_ready(reqReady1),
    .fifo_wdata(fifoWdata1), .fifo_winc(fifoWinc1), .fifo_wfull(fifoWfull1),
    .grant_valid(grantValid1), .grant_id(grantId1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // The monitor pops the owner's scoreboard on every write it sees.
  always @(negedge clk) begin
    if (fifoWinc === 1'b1) begin
      checkOutput("wincWhileFull", 32'(fifoWfull), 32'd0);
      checkOutput("readyOneHot", 32'(reqReady), 32'(4'b0001 << grantId));
      if (expQ[grantId].size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedWrite: got data %0h from id %0d, expected no write", fifoWdata, grantId);
      end else begin
        checkOutput("wdata", 32'(fifoWdata), 32'(expQ[grantId].pop_front()));
      end
    end
  end

  task automatic driveProducers();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < n[i]) begin
        reqValid[i]         = 1'b1;
        reqData[i*8 +: 8]   = words[i][pos[i]];
      end else begin
        reqValid[i]         = 1'b0;
        reqData[i*8 +: 8]   = 8'h00;
      end
    end
  endtask

  // Advance one clock; accepted handshakes move each producer to its next word.
  task automatic tick();
    @(negedge clk);
    acc = reqValid & reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) pos[i]++;
    driveProducers();
    #1;
  endtask

  task automatic applyStimulus(input int r, input int count, input logic [7:0] base);
    for (int k = 0; k < count; k++) begin
      words[r][k] = base + 8'(k);
      expQ[r].push_back(base + 8'(k));
    end
    n[r]   = count;
    pos[r] = 0;
    driveProducers();
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_grantValid"}, 32'(grantValid), 32'd0);
    checkOutput({tag, "_winc"}, 32'(fifoWinc), 32'd0);
    checkOutput({tag, "_ready"}, 32'(reqReady), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(fifoWdata), 32'd0);
    checkOutput({tag, "_grantId"}, 32'(grantId), 32'd0);
  endtask

  task automatic resetAll();
    rst = 1'b1;
    fifoWfull = 1'b0;
    reqValid1 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      pos[i] = 0;
      expQ[i].delete();
    end
    driveProducers();
    #1;
    checkQuiet("duringReset");
    tick();
    rst = 1'b0;
    #1;
    checkQuiet("afterReset");
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 20 && grantValid; k++) tick();
    checkOutput("waitIdleTimeout", 32'(grantValid), 32'd0);
  endtask

  task automatic waitDrained(input string tag);
    int left;
    bit busy;
    busy = 1'b1;
    for (int k = 0; k < 200 && busy; k++) begin
      busy = grantValid;
      for (int i = 0; i < 4; i++) if (pos[i] < n[i]) busy = 1'b1;
      if (busy) tick();
    end
    left = 0;
    for (int i = 0; i < 4; i++) left += expQ[i].size();
    checkOutput({tag, "_drainTimeout"}, 32'(busy), 32'd0);
    checkOutput({tag, "_wordsMissing"}, 32'(left), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    fifoWfull  = 1'b0;
    fifoWfull1 = 1'b0;
    reqValid   = 4'b0000;
    reqData    = 32'h0;
    reqValid1  = 4'b0000;
    reqData1   = {8'h53, 8'h52, 8'h51, 8'h50};
    acc        = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n[i] = 0;
      pos[i] = 0;
    end

    // 1: single requester, three words then drop; grant one cycle after valid.
    resetAll();
    applyStimulus(0, 3, 8'hA1);
    #1;
    checkOutput("t1_latencyIdle", 32'(grantValid), 32'd0);
    tick();
    checkOutput("t1_grantValid", 32'(grantValid), 32'd1);
    checkOutput("t1_grantId", 32'(grantId), 32'd0);
    checkOutput("t1_firstWinc", 32'(fifoWinc), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("t1_dropEndsWinc", 32'(fifoWinc), 32'd0);
    tick();
    checkOutput("t1_backToIdle", 32'(grantValid), 32'd0);
    applyStimulus(0, 1, 8'hB0);
    applyStimulus(1, 1, 8'hB1);
    tick();
    checkOutput("t1_ptrIsOne", 32'(grantId), 32'd1);
    waitDrained("t1");

    // 2: all four continuously valid; 5-cycle period, owner rotates 0..3 twice.
    resetAll();
    for (int i = 0; i < 4; i++) applyStimulus(i, 8, 8'(i * 16));
    for (int c = 0; c < 40; c++) begin
      checkOutput("t2_grantValid", 32'(grantValid), 32'((c % 5) != 0));
      if ((c % 5) != 0) checkOutput("t2_grantId", 32'(grantId), 32'((c / 5) % 4));
      tick();
    end
    waitDrained("t2");

    // 3: FIFO full for 5 cycles after the 2nd word; burst still ends at 4 words.
    resetAll();
    applyStimulus(1, 6, 8'h30);
    tick();
    tick();
    tick();
    fifoWfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput("t3_stallWinc", 32'(fifoWinc), 32'd0);
      checkOutput("t3_stallReady", 32'(reqReady), 32'd0);
      checkOutput("t3_stallHold", 32'(grantValid), 32'd1);
      checkOutput("t3_stallId", 32'(grantId), 32'd1);
      tick();
    end
    fifoWfull = 1'b0;
    #1;
    checkOutput("t3_word3", 32'(fifoWinc), 32'd1);
    tick();
    checkOutput("t3_word4", 32'(fifoWinc), 32'd1);
    tick();
    checkOutput("t3_burstEnded", 32'(grantValid), 32'd0);
    waitDrained("t3");

    // 4: after requester 2 finishes, search starts at 3 so requester 0 beats 2.
    resetAll();
    applyStimulus(2, 1, 8'hC0);
    tick();
    waitIdle();
    applyStimulus(0, 1, 8'hD0);
    applyStimulus(2, 1, 8'hC8);
    tick();
    checkOutput("t4_rotationValid", 32'(grantValid), 32'd1);
    checkOutput("t4_rotationId", 32'(grantId), 32'd0);
    waitDrained("t4");

    // 5: reset after two words of a burst.
    resetAll();
    applyStimulus(1, 6, 8'hE0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkQuiet("t5_inReset");
    n[1] = pos[1];
    expQ[1].delete();
    tick();
    rst = 1'b0;
    #1;
    checkQuiet("t5_afterReset");
    applyStimulus(3, 1, 8'hF0);
    tick();
    checkOutput("t5_grantValid", 32'(grantValid), 32'd1);
    checkOutput("t5_grantId", 32'(grantId), 32'd3);
    waitDrained("t5");

    // 6: MAX_BURST=1 with requesters 0 and 1 always valid; single-word grants alternate.
    resetAll();
    reqValid1 = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("t6_wincPattern", 32'(fifoWinc1), 32'(k % 2));
      if ((k % 2) == 1) begin
        checkOutput("t6_grantId", 32'(grantId1), 32'((k / 2) % 2));
        checkOutput("t6_wdata", 32'(fifoWdata1), 32'(8'h50 + 8'((k / 2) % 2)));
      end
      tick();
    end
    reqValid1 = 4'b0000;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
